// File: rtl/encoder_feeder.sv
// Byte-to-bit feeder for the convolutional encoder. Bytes are sent MSB first,
// each bit is handshaked against out_enable, and K-1 zero tail bits end a frame.
module encoder_feeder #(
  parameter int TIMEOUT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic [1:0] constraint_sel,
  output logic [1:0] enc_constraint_sel,
  output logic       data_in,
  output logic       in_enable,
  input  logic       enc_out_enable,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] tail_cnt, tail_cnt_nxt;
  logic [3:0] timer, timer_nxt;
  logic       last_q, last_nxt;
  logic       in_tail, in_tail_nxt;
  logic       frame_open, frame_open_nxt;
  logic [1:0] ksel_nxt;
  logic       ready_nxt, data_nxt, in_enable_nxt, busy_nxt;
  logic       frame_done_nxt, timeout_nxt;
  logic       to_gap;

  // Number of flush bits (K-1) for a constraint select.
  function automatic logic [2:0] tail_len(input logic [1:0] sel);
    case (sel)
      2'b00:   tail_len = 3'd2;
      2'b01:   tail_len = 3'd3;
      2'b10:   tail_len = 3'd4;
      default: tail_len = 3'd6;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      shreg              <= 8'd0;
      bit_cnt            <= 4'd0;
      tail_cnt           <= 3'd0;
      timer              <= 4'd0;
      last_q             <= 1'b0;
      in_tail            <= 1'b0;
      frame_open         <= 1'b0;
      enc_constraint_sel <= 2'b00;
      byte_ready         <= 1'b1;
      data_in            <= 1'b0;
      in_enable          <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state              <= state_nxt;
      shreg              <= shreg_nxt;
      bit_cnt            <= bit_cnt_nxt;
      tail_cnt           <= tail_cnt_nxt;
      timer              <= timer_nxt;
      last_q             <= last_nxt;
      in_tail            <= in_tail_nxt;
      frame_open         <= frame_open_nxt;
      enc_constraint_sel <= ksel_nxt;
      byte_ready         <= ready_nxt;
      data_in            <= data_nxt;
      in_enable          <= in_enable_nxt;
      busy               <= busy_nxt;
      frame_done         <= frame_done_nxt;
      timeout_err        <= timeout_nxt;
    end
  end

  // Outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    tail_cnt_nxt   = tail_cnt;
    timer_nxt      = timer;
    last_nxt       = last_q;
    in_tail_nxt    = in_tail;
    frame_open_nxt = frame_open;
    ksel_nxt       = enc_constraint_sel;
    data_nxt       = 1'b0;
    in_enable_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    timeout_nxt    = timeout_err;
    to_gap         = 1'b0;

    case (state)
      IDLE: begin
        if (byte_valid && byte_ready) begin
          shreg_nxt     = byte_in;
          last_nxt      = byte_last;
          bit_cnt_nxt   = 4'd8;
          in_tail_nxt   = 1'b0;
          data_nxt      = byte_in[7];
          in_enable_nxt = 1'b1;
          state_nxt     = SEND;
          if (!frame_open) begin
            ksel_nxt       = constraint_sel;
            frame_open_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (in_tail) tail_cnt_nxt = tail_cnt - 3'd1;
        else         bit_cnt_nxt  = bit_cnt - 4'd1;
        timer_nxt = 4'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (enc_out_enable) begin
          to_gap = 1'b1;
        end else begin
          timer_nxt = timer + 4'd1;
          if (timer_nxt == TIMEOUT_LIM) begin
            to_gap      = 1'b1;
            timeout_nxt = 1'b1;
          end
        end
        if (to_gap) begin
          state_nxt = GAP;
          // The GAP being entered is the frame's last one when the tail is exhausted.
          frame_done_nxt = in_tail && (tail_cnt == 3'd0);
        end
      end
      GAP: begin
        if (bit_cnt != 4'd0) begin
          shreg_nxt     = {shreg[6:0], 1'b0};
          data_nxt      = shreg[6];
          in_enable_nxt = 1'b1;
          state_nxt     = SEND;
        end else if (tail_cnt != 3'd0) begin
          in_enable_nxt = 1'b1;
          state_nxt     = SEND;
        end else if (!in_tail && last_q) begin
          tail_cnt_nxt  = tail_len(enc_constraint_sel);
          in_tail_nxt   = 1'b1;
          in_enable_nxt = 1'b1;
          state_nxt     = SEND;
        end else if (in_tail) begin
          in_tail_nxt    = 1'b0;
          frame_open_nxt = 1'b0;
          state_nxt      = IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_encoder_feeder.sv
// Directed bench for encoder_feeder with a one-cycle-latency encoder model.
module tb_encoder_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;
  logic       byte_ready;
  logic [1:0] constraint_sel = 2'b00;
  logic [1:0] enc_constraint_sel;
  logic       data_in;
  logic       in_enable;
  logic       enc_out_enable;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;
  logic       model_en = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_bad = 0;

  int         st_cyc[$];
  bit         st_dat[$];
  bit         st_to[$];
  logic [1:0] st_k[$];
  int         fd_cyc[$];

  encoder_feeder #(.TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready),
    .constraint_sel(constraint_sel), .enc_constraint_sel(enc_constraint_sel),
    .data_in(data_in), .in_enable(in_enable), .enc_out_enable(enc_out_enable),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst)
    if (rst) enc_out_enable <= 1'b0;
    else     enc_out_enable <= model_en & in_enable;

  always @(negedge clk) begin
    if (in_enable) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(data_in);
      st_to.push_back(timeout_err);
      st_k.push_back(enc_constraint_sel);
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (!rst && (busy == byte_ready)) ready_bad++;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log;
    st_cyc.delete(); st_dat.delete(); st_to.delete(); st_k.delete();
    fd_cyc.delete(); ready_bad = 0;
  endtask

  // Presents a byte and returns the cycle number of its SEND cycle; valid stays high.
  task automatic offer(input logic [7:0] b, input logic l, output int acc);
    int n;
    byte_in = b; byte_last = l; byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 300) begin step(); n++; end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL offer_timeout: byte_ready=%0b required 1", byte_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    step();
    while (busy && n < budget) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0b need 1", byte_ready); end
    checks++; if (in_enable !== 1'b0) begin failures++; $display("FAIL rst_in_enable: got %0b need 0", in_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b need 0", busy); end
    checks++; if (frame_done !== 1'b0 || timeout_err !== 1'b0 || data_in !== 1'b0) begin
      failures++; $display("FAIL rst_flags: fd=%0b to=%0b d=%0b need 0", frame_done, timeout_err, data_in);
    end
    checks++; if (enc_constraint_sel !== 2'b00) begin failures++; $display("FAIL rst_ksel: got %0d need 0", enc_constraint_sel); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_k3;
    int acc;
    logic [9:0] exp;
    exp = 10'b0100010100;
    model_en = 1'b1; constraint_sel = 2'b00; clear_log();
    offer(8'h45, 1'b1, acc);
    byte_valid = 1'b0;
    wait_idle(200);
    checks++; if (st_dat.size() !== 10) begin failures++; $display("FAIL k3_strobes: got %0d need 10", st_dat.size()); end
    for (int i = 0; i < 10 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp[9-i]) begin failures++; $display("FAIL k3_bit%0d: got %0b need %0b", i, st_dat[i], exp[9-i]); end
    end
    checks++; if (st_cyc.size() > 0 && st_cyc[0] !== acc) begin failures++; $display("FAIL k3_first_strobe: got %0d need %0d", st_cyc[0], acc); end
    for (int i = 0; i + 1 < st_cyc.size(); i++) begin
      checks++;
      if (st_cyc[i+1] - st_cyc[i] !== 3) begin failures++; $display("FAIL k3_spacing%0d: got %0d need 3", i, st_cyc[i+1] - st_cyc[i]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin failures++; $display("FAIL k3_fd_count: got %0d need 1", fd_cyc.size()); end
    checks++; if (fd_cyc.size() > 0 && fd_cyc[0] !== acc + 29) begin failures++; $display("FAIL k3_fd_cycle: got %0d need %0d", fd_cyc[0], acc + 29); end
    checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL k3_ready_after: got %0b need 1", byte_ready); end
    checks++; if (ready_bad !== 0) begin failures++; $display("FAIL k3_ready_busy: got %0d bad cycles need 0", ready_bad); end
  endtask

  task automatic test_two_bytes_k7;
    int a1, a2;
    logic [21:0] exp;
    exp = {8'hA5, 8'h3C, 6'b000000};
    constraint_sel = 2'b11; clear_log();
    offer(8'hA5, 1'b0, a1);
    offer(8'h3C, 1'b1, a2);
    byte_valid = 1'b0;
    wait_idle(300);
    checks++; if (st_dat.size() !== 22) begin failures++; $display("FAIL k7_strobes: got %0d need 22", st_dat.size()); end
    for (int i = 0; i < 22 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp[21-i]) begin failures++; $display("FAIL k7_bit%0d: got %0b need %0b", i, st_dat[i], exp[21-i]); end
    end
    checks++; if (a2 - a1 !== 25) begin failures++; $display("FAIL k7_second_accept: got %0d need 25", a2 - a1); end
    checks++; if (st_cyc.size() > 8 && st_cyc[8] - st_cyc[7] !== 4) begin failures++; $display("FAIL k7_no_mid_tail: got %0d need 4", st_cyc[8] - st_cyc[7]); end
    checks++; if (fd_cyc.size() !== 1) begin failures++; $display("FAIL k7_fd_count: got %0d need 1", fd_cyc.size()); end
    checks++; if (ready_bad !== 0) begin failures++; $display("FAIL k7_ready_busy: got %0d need 0", ready_bad); end
    checks++; if (st_k.size() > 21 && st_k[21] !== 2'b11) begin failures++; $display("FAIL k7_ksel: got %0d need 3", st_k[21]); end
  endtask

  task automatic test_k_change;
    int acc;
    logic [9:0] exp;
    exp = {8'hC3, 2'b00};
    constraint_sel = 2'b00; clear_log();
    offer(8'hC3, 1'b1, acc);
    byte_valid = 1'b0;
    step(); step();
    constraint_sel = 2'b11;
    wait_idle(200);
    checks++; if (st_dat.size() !== 10) begin failures++; $display("FAIL kchg_strobes: got %0d need 10", st_dat.size()); end
    for (int i = 0; i < 10 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp[9-i] || st_k[i] !== 2'b00) begin
        failures++; $display("FAIL kchg_bit%0d: got d=%0b k=%0d need d=%0b k=0", i, st_dat[i], st_k[i], exp[9-i]);
      end
    end
    checks++; if (enc_constraint_sel !== 2'b00) begin failures++; $display("FAIL kchg_ksel_end: got %0d need 0", enc_constraint_sel); end
    // The next frame must pick up the new select.
    clear_log();
    offer(8'h01, 1'b1, acc);
    byte_valid = 1'b0;
    wait_idle(200);
    checks++; if (st_dat.size() !== 14) begin failures++; $display("FAIL kchg_next_strobes: got %0d need 14", st_dat.size()); end
    checks++; if (enc_constraint_sel !== 2'b11) begin failures++; $display("FAIL kchg_next_ksel: got %0d need 3", enc_constraint_sel); end
  endtask

  task automatic test_back_to_back;
    int a1, a2;
    logic [17:0] exp;
    exp = {8'h55, 8'h12, 2'b00};
    constraint_sel = 2'b00; clear_log();
    offer(8'h55, 1'b0, a1);
    offer(8'h12, 1'b1, a2);
    byte_valid = 1'b0;
    wait_idle(300);
    checks++; if (a2 - a1 !== 25) begin failures++; $display("FAIL hold_accept: got %0d need 25", a2 - a1); end
    checks++; if (st_dat.size() !== 18) begin failures++; $display("FAIL hold_strobes: got %0d need 18", st_dat.size()); end
    for (int i = 0; i < 18 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp[17-i]) begin failures++; $display("FAIL hold_bit%0d: got %0b need %0b", i, st_dat[i], exp[17-i]); end
    end
    checks++; if (ready_bad !== 0) begin failures++; $display("FAIL hold_ready_busy: got %0d need 0", ready_bad); end
  endtask

  task automatic test_timeout;
    int acc;
    logic [10:0] exp;
    exp = {8'hFF, 3'b000};
    model_en = 1'b0; constraint_sel = 2'b01; clear_log();
    offer(8'hFF, 1'b1, acc);
    byte_valid = 1'b0;
    wait_idle(400);
    checks++; if (st_dat.size() !== 11) begin failures++; $display("FAIL to_strobes: got %0d need 11", st_dat.size()); end
    for (int i = 0; i < 11 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp[10-i]) begin failures++; $display("FAIL to_bit%0d: got %0b need %0b", i, st_dat[i], exp[10-i]); end
    end
    for (int i = 0; i + 1 < st_cyc.size(); i++) begin
      checks++;
      if (st_cyc[i+1] - st_cyc[i] !== 7) begin failures++; $display("FAIL to_spacing%0d: got %0d need 7", i, st_cyc[i+1] - st_cyc[i]); end
    end
    checks++; if (st_to.size() > 1 && (st_to[0] !== 1'b0 || st_to[1] !== 1'b1)) begin
      failures++; $display("FAIL to_rise: got %0b,%0b need 0,1", st_to[0], st_to[1]);
    end
    checks++; if (fd_cyc.size() > 0 && fd_cyc[0] !== acc + 76) begin failures++; $display("FAIL to_fd_cycle: got %0d need %0d", fd_cyc[0], acc + 76); end
    step(); step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %0b need 1", timeout_err); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    int acc, n;
    logic [11:0] exp;
    exp = 12'h800;
    constraint_sel = 2'b00; clear_log();
    offer(8'hF0, 1'b1, acc);
    byte_valid = 1'b0;
    n = 0;
    while (st_cyc.size() < 3 && n < 50) begin step(); n++; end
    checks++; if (in_enable !== 1'b1) begin failures++; $display("FAIL mid_pre_strobe: got %0b need 1", in_enable); end
    rst = 1'b1;
    #1;
    checks++; if (in_enable !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL mid_rst_outputs: ie=%0b busy=%0b to=%0b need 0,0,0", in_enable, busy, timeout_err);
    end
    step();
    rst = 1'b0;
    step();
    checks++; if (byte_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %0b need 1", byte_ready); end
    constraint_sel = 2'b10; clear_log();
    offer(8'h80, 1'b1, acc);
    byte_valid = 1'b0;
    wait_idle(300);
    checks++; if (st_dat.size() !== 12) begin failures++; $display("FAIL mid_new_strobes: got %0d need 12", st_dat.size()); end
    for (int i = 0; i < 12 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp[11-i]) begin failures++; $display("FAIL mid_new_bit%0d: got %0b need %0b", i, st_dat[i], exp[11-i]); end
    end
    checks++; if (st_k.size() > 0 && st_k[0] !== 2'b10) begin failures++; $display("FAIL mid_new_ksel: got %0d need 2", st_k[0]); end
    checks++; if (fd_cyc.size() !== 1) begin failures++; $display("FAIL mid_new_fd: got %0d need 1", fd_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_single_k3();
    test_two_bytes_k7();
    test_k_change();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "global timeout");
  end

endmodule
